cordic_bus_regs: RTL and testbench

- Host-side register responder for the CORDIC accelerator, sitting at the opposite end of the controller's bus interface.
- Terminates an APB3-style slave port and holds the operand and control registers the controller samples.
- Captures the controller's write-backs (control/flag word, results) and converts its interrupt line into sticky, maskable status.
- Tracks each job through a start handshake FSM, so software cannot double-start or miss completion.

---
 rtl/cordic_pkg.sv | 38 +++
 rtl/cordic_irq_ctrl.sv | 49 ++++
 rtl/cordic_bus_regs.sv | 152 +++++++++++++++
 tb/tb_cordic_bus_regs.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared register map, control/flag bit positions and job-state encoding for
// the CORDIC host register block.
package cordic_pkg;

  localparam logic [3:0] REG_CTRL      = 4'h0;
  localparam logic [3:0] REG_X_IN      = 4'h1;
  localparam logic [3:0] REG_Y_IN      = 4'h2;
  localparam logic [3:0] REG_Z_IN      = 4'h3;
  localparam logic [3:0] REG_X_RES     = 4'h4;
  localparam logic [3:0] REG_Y_RES     = 4'h5;
  localparam logic [3:0] REG_Z_RES     = 4'h6;
  localparam logic [3:0] REG_IRQ_EN    = 4'h7;
  localparam logic [3:0] REG_IRQ_STAT  = 4'h8;
  localparam logic [3:0] REG_JOB_STATE = 4'h9;

  localparam int CNTRL_START    = 0;
  localparam int CNTRL_STOP     = 1;
  localparam int CNTRL_ITER_LO  = 8;
  localparam int CNTRL_ITER_HI  = 12;
  localparam int FLAG_READY     = 16;
  localparam int FLAG_INP_ERR   = 17;
  localparam int FLAG_OV_ERR    = 18;
  localparam int ELAPS_ITER_LO  = 19;
  localparam int ELAPS_ITER_HI  = 23;

  localparam int STAT_DONE = 0;
  localparam int STAT_ERR  = 1;

  localparam logic [31:0] CTRL_RESET = 32'h0000_1F3C;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_START_PEND = 2'd1,
    S_RUNNING    = 2'd2,
    S_DONE       = 2'd3
  } job_state_e;

endpackage

// File: rtl/cordic_irq_ctrl.sv
// Interrupt path: rising-edge detect on the controller irq, sticky W1C status
// with set priority, enable mask and a registered host interrupt.
module cordic_irq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cordic_irq_i,
  input  logic [1:0] set_i,
  input  logic [1:0] w1c_i,
  input  logic       en_we_i,
  input  logic [1:0] en_wdata_i,
  output logic       irq_rise_o,
  output logic [1:0] stat_o,
  output logic [1:0] en_o,
  output logic       irq_o
);

  logic       dly_q;
  logic [1:0] stat_q, stat_d;
  logic [1:0] en_q, en_d;
  logic       irq_q, irq_d;

  assign irq_rise_o = cordic_irq_i & ~dly_q;

  // Set is OR'ed in after the clear so a same-cycle event is never lost.
  always_comb begin
    stat_d = (stat_q & ~w1c_i) | set_i;
    en_d   = en_we_i ? en_wdata_i : en_q;
    irq_d  = |(stat_q & en_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_q  <= 1'b0;
      stat_q <= '0;
      en_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      dly_q  <= cordic_irq_i;
      stat_q <= stat_d;
      en_q   <= en_d;
      irq_q  <= irq_d;
    end
  end

  assign stat_o = stat_q;
  assign en_o   = en_q;
  assign irq_o  = irq_q;

endmodule

// File: rtl/cordic_bus_regs.sv
// APB3 zero-wait-state register responder for the CORDIC controller: operand
// and control registers, result/flag capture and the job start handshake FSM.
module cordic_bus_regs
  import cordic_pkg::*;
#(
  parameter int          p_WIDTH      = 32,
  parameter int          p_ADDR_WIDTH = 6,
  parameter logic [31:0] p_CTRL_RESET = CTRL_RESET
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [p_ADDR_WIDTH-1:0] paddr,
  input  logic [p_WIDTH-1:0]      pwdata,
  output logic [p_WIDTH-1:0]      prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [31:0]             ctrl_in,
  output logic [p_WIDTH-1:0]      x_in,
  output logic [p_WIDTH-1:0]      y_in,
  output logic [p_WIDTH-1:0]      z_in,
  input  logic [31:0]             ctrl_out,
  input  logic                    ctrl_wr_en,
  input  logic [p_WIDTH-1:0]      x_res,
  input  logic [p_WIDTH-1:0]      y_res,
  input  logic [p_WIDTH-1:0]      z_res,
  input  logic                    cordic_irq,
  output logic                    irq
);

  job_state_e         state_q, state_d;
  logic [15:0]        ctrl_q, ctrl_d;
  logic [p_WIDTH-1:0] x_q, y_q, z_q;

  logic       access, mapped, ro, start_blk, err, wr_ok;
  logic       wr_ctrl, wr_stat, wr_en, start_wr, start_taken, done_evt;
  logic       irq_rise;
  logic [3:0] ofs;
  logic [1:0] set, w1c, irq_en, irq_stat;
  logic       unused_addr;

  assign ofs         = paddr[5:2];
  assign unused_addr = ^paddr[1:0];

  // Outputs are gated by reset so the bus sees an idle slave during reset.
  assign access = psel & penable & ~rst;

  always_comb begin
    mapped    = (ofs <= REG_JOB_STATE);
    ro        = (ofs inside {REG_X_RES, REG_Y_RES, REG_Z_RES, REG_JOB_STATE});
    start_blk = (ofs == REG_CTRL) && pwdata[CNTRL_START] &&
                !(state_q inside {S_IDLE, S_DONE});
    err       = access & (~mapped | (pwrite & (ro | start_blk)));
    wr_ok     = access & pwrite & ~err;
  end

  assign wr_ctrl     = wr_ok & (ofs == REG_CTRL);
  assign wr_stat     = wr_ok & (ofs == REG_IRQ_STAT);
  assign wr_en       = wr_ok & (ofs == REG_IRQ_EN);
  assign start_wr    = wr_ctrl & pwdata[CNTRL_START];
  assign start_taken = (state_q == S_START_PEND) & ctrl_wr_en;
  assign done_evt    = (state_q == S_RUNNING) & (irq_rise | ctrl_out[FLAG_READY]);

  assign set[STAT_DONE] = done_evt;
  assign set[STAT_ERR]  = done_evt & (ctrl_out[FLAG_INP_ERR] | ctrl_out[FLAG_OV_ERR]);
  assign w1c            = {2{wr_stat}} & pwdata[1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (start_wr) state_d = S_START_PEND;
      S_START_PEND: if (ctrl_wr_en) state_d = S_RUNNING;
      S_RUNNING:    if (done_evt) state_d = S_DONE;
      S_DONE: begin
        if (start_wr)               state_d = S_START_PEND;
        else if (w1c[STAT_DONE])    state_d = S_IDLE;
      end
      default:      state_d = S_IDLE;
    endcase
  end

  // START is sticky until the controller acknowledges; STOP self-clears.
  always_comb begin
    ctrl_d             = ctrl_q;
    ctrl_d[CNTRL_STOP] = 1'b0;
    if (start_taken) ctrl_d[CNTRL_START] = 1'b0;
    if (wr_ctrl) begin
      ctrl_d[15:2]       = pwdata[15:2];
      ctrl_d[CNTRL_STOP] = pwdata[CNTRL_STOP];
      if (pwdata[CNTRL_START]) ctrl_d[CNTRL_START] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ctrl_q  <= p_CTRL_RESET[15:0];
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      if (wr_ok && ofs == REG_X_IN) x_q <= pwdata;
      if (wr_ok && ofs == REG_Y_IN) y_q <= pwdata;
      if (wr_ok && ofs == REG_Z_IN) z_q <= pwdata;
    end
  end

  cordic_irq_ctrl u_irq (
    .clk          (clk),
    .rst          (rst),
    .cordic_irq_i (cordic_irq),
    .set_i        (set),
    .w1c_i        (w1c),
    .en_we_i      (wr_en),
    .en_wdata_i   (pwdata[1:0]),
    .irq_rise_o   (irq_rise),
    .stat_o       (irq_stat),
    .en_o         (irq_en),
    .irq_o        (irq)
  );

  always_comb begin
    prdata = '0;
    if (access) begin
      unique case (ofs)
        REG_CTRL:      prdata = p_WIDTH'(ctrl_out);
        REG_X_IN:      prdata = x_q;
        REG_Y_IN:      prdata = y_q;
        REG_Z_IN:      prdata = z_q;
        REG_X_RES:     prdata = x_res;
        REG_Y_RES:     prdata = y_res;
        REG_Z_RES:     prdata = z_res;
        REG_IRQ_EN:    prdata = p_WIDTH'(irq_en);
        REG_IRQ_STAT:  prdata = p_WIDTH'(irq_stat);
        REG_JOB_STATE: prdata = p_WIDTH'(state_q);
        default:       prdata = '0;
      endcase
    end
  end

  assign pready  = access;
  assign pslverr = err;
  assign ctrl_in = {16'h0000, ctrl_q};
  assign x_in    = x_q;
  assign y_in    = y_q;
  assign z_in    = z_q;

endmodule

// File: tb/tb_cordic_bus_regs.sv
// Directed bench for cordic_bus_regs: register map vectors from a table, then
// hand sequences for the start handshake, completion, W1C and reset corners.
module tb_cordic_bus_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [5:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [31:0] ctrl_in, x_in, y_in, z_in;
  logic [31:0] ctrl_out;
  logic        ctrl_wr_en;
  logic [31:0] x_res, y_res, z_res;
  logic        cordic_irq, irq;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  cordic_bus_regs dut (
    .clk        (clk),
    .rst        (rst),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .ctrl_in    (ctrl_in),
    .x_in       (x_in),
    .y_in       (y_in),
    .z_in       (z_in),
    .ctrl_out   (ctrl_out),
    .ctrl_wr_en (ctrl_wr_en),
    .x_res      (x_res),
    .y_res      (y_res),
    .z_res      (z_res),
    .cordic_irq (cordic_irq),
    .irq        (irq)
  );

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // evt drives a completion flag on ctrl_out exactly at the access-phase edge.
  task automatic apb(input logic wr, input logic [5:0] a, input logic [31:0] wd,
                     input logic evt, output logic [31:0] rd, output logic er);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    if (evt) ctrl_out = 32'h0001_0000;
    #1;
    rd = prdata; er = pslverr;
    chk("pready", {31'b0, pready}, 32'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    if (evt) ctrl_out = 32'h0;
  endtask

  task automatic wr_ok(input string name, input logic [5:0] a, input logic [31:0] wd, input logic evt);
    logic [31:0] rd; logic er;
    apb(1'b1, a, wd, evt, rd, er);
    chk(name, {31'b0, er}, 32'd0);
  endtask

  task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic er;
    apb(1'b0, a, 32'h0, 1'b0, rd, er);
    chk(name, rd, exp);
  endtask

  task automatic pulse_wr_en();
    @(negedge clk); ctrl_wr_en = 1'b1;
    @(posedge clk); #1; ctrl_wr_en = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    rst = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    ctrl_out = 32'h0000_ABCD; ctrl_wr_en = 0; cordic_irq = 0;
    x_res = 32'hA5A5_0001; y_res = 32'h5A5A_0002; z_res = 32'h0F0F_0003;

    vecs[0]  = '{1'b1, 6'h04, 32'h1234_5678, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 6'h04, 32'h0,         1'b1, 32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b1, 6'h08, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 6'h08, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 6'h0C, 32'h0000_00FF, 1'b0, 32'h0,         1'b0};
    vecs[5]  = '{1'b0, 6'h0C, 32'h0,         1'b1, 32'h0000_00FF, 1'b0};
    vecs[6]  = '{1'b0, 6'h10, 32'h0,         1'b1, 32'hA5A5_0001, 1'b0};
    vecs[7]  = '{1'b0, 6'h14, 32'h0,         1'b1, 32'h5A5A_0002, 1'b0};
    vecs[8]  = '{1'b0, 6'h18, 32'h0,         1'b1, 32'h0F0F_0003, 1'b0};
    vecs[9]  = '{1'b1, 6'h1C, 32'hFFFF_FFFE, 1'b0, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 6'h1C, 32'h0,         1'b1, 32'h0000_0002, 1'b0};
    vecs[11] = '{1'b1, 6'h1C, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 6'h1C, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[13] = '{1'b0, 6'h20, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[14] = '{1'b0, 6'h24, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[15] = '{1'b0, 6'h00, 32'h0,         1'b1, 32'h0000_ABCD, 1'b0};
    vecs[16] = '{1'b1, 6'h10, 32'h1111_1111, 1'b0, 32'h0,         1'b1};
    vecs[17] = '{1'b1, 6'h24, 32'h0000_0003, 1'b0, 32'h0,         1'b1};
    vecs[18] = '{1'b0, 6'h3C, 32'h0,         1'b1, 32'h0,         1'b1};
    vecs[19] = '{1'b1, 6'h28, 32'h2222_2222, 1'b0, 32'h0,         1'b1};
    vecs[20] = '{1'b0, 6'h10, 32'h0,         1'b1, 32'hA5A5_0001, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst ctrl_in", ctrl_in, 32'h0000_1F3C);
    chk("rst x_in", x_in, 32'h0);
    chk("rst irq", {31'b0, irq}, 32'h0);
    chk("rst pready", {31'b0, pready}, 32'h0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, er);
      chk($sformatf("vec%0d pslverr", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      if (vecs[i].chk_rd) chk($sformatf("vec%0d prdata", i), rd, vecs[i].exp_rd);
    end
    chk("y_in", y_in, 32'hDEAD_BEEF);
    chk("z_in", z_in, 32'h0000_00FF);

    // start handshake with a rejected double start
    wr_ok("wr X", 6'h04, 32'h4000_0000, 1'b0);
    wr_ok("wr Z", 6'h0C, 32'h2000_0000, 1'b0);
    wr_ok("wr CTRL start", 6'h00, 32'h0000_1F35, 1'b0);
    chk("ctrl_in after start", ctrl_in, 32'h0000_1F35);
    apb(1'b1, 6'h00, 32'h0000_0001, 1'b0, rd, er);
    chk("double start pslverr", {31'b0, er}, 32'd1);
    chk("double start ctrl_in", ctrl_in, 32'h0000_1F35);
    rd_chk("job pend", 6'h24, 32'd1);
    @(negedge clk); ctrl_wr_en = 1'b1; #1;
    chk("start held at ack", {31'b0, ctrl_in[0]}, 32'd1);
    @(posedge clk); #1; ctrl_wr_en = 1'b0;
    chk("start cleared", ctrl_in, 32'h0000_1F34);
    rd_chk("job running", 6'h24, 32'd2);
    chk("x_in op", x_in, 32'h4000_0000);
    chk("z_in op", z_in, 32'h2000_0000);

    // completion via cordic_irq rising edge
    wr_ok("wr IRQ_EN 1", 6'h1C, 32'h1, 1'b0);
    @(negedge clk); cordic_irq = 1'b1; ctrl_out = 32'h0001_0000;
    @(posedge clk); #1;
    chk("irq latency", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("irq asserted", {31'b0, irq}, 32'd1);
    @(negedge clk); cordic_irq = 1'b0; ctrl_out = 32'h0;
    rd_chk("stat done", 6'h20, 32'h1);
    rd_chk("job done", 6'h24, 32'd3);
    wr_ok("w1c done", 6'h20, 32'h1, 1'b0);
    chk("irq still registered", {31'b0, irq}, 32'd1);
    @(posedge clk); #1;
    chk("irq cleared", {31'b0, irq}, 32'd0);
    rd_chk("job idle", 6'h24, 32'd0);

    // error completion and STOP pulse while running
    wr_ok("start 2", 6'h00, 32'h1, 1'b0);
    chk("ctrl_in start 2", ctrl_in, 32'h0000_0001);
    pulse_wr_en();
    wr_ok("wr IRQ_EN 2", 6'h1C, 32'h2, 1'b0);
    wr_ok("stop", 6'h00, 32'h2, 1'b0);
    chk("stop high", ctrl_in, 32'h0000_0002);
    @(posedge clk); #1;
    chk("stop low", ctrl_in, 32'h0000_0000);
    rd_chk("job running after stop", 6'h24, 32'd2);
    @(negedge clk); cordic_irq = 1'b1; ctrl_out = 32'h0004_0000;
    @(negedge clk); cordic_irq = 1'b0; ctrl_out = 32'h0;
    rd_chk("stat err", 6'h20, 32'h3);
    chk("irq on err", {31'b0, irq}, 32'd1);

    // restart from DONE, then W1C of DONE racing a new completion: set wins
    wr_ok("restart from done", 6'h00, 32'h1, 1'b0);
    rd_chk("job pend 3", 6'h24, 32'd1);
    pulse_wr_en();
    wr_ok("w1c vs set", 6'h20, 32'h1, 1'b1);
    rd_chk("stat set wins", 6'h20, 32'h3);
    rd_chk("job done 3", 6'h24, 32'd3);

    // STOP write on the same edge as completion
    wr_ok("w1c all", 6'h20, 32'h3, 1'b0);
    rd_chk("job idle 4", 6'h24, 32'd0);
    wr_ok("start 4", 6'h00, 32'h1, 1'b0);
    pulse_wr_en();
    wr_ok("stop at done", 6'h00, 32'h2, 1'b1);
    chk("stop with done", ctrl_in, 32'h0000_0002);
    rd_chk("job done 4", 6'h24, 32'd3);
    rd_chk("stat done 4", 6'h20, 32'h1);

    // asynchronous reset in the middle of a running job
    wr_ok("start 5", 6'h00, 32'h1, 1'b0);
    pulse_wr_en();
    wr_ok("wr IRQ_EN 3", 6'h1C, 32'h3, 1'b0);
    @(posedge clk); #1;
    chk("irq before reset", {31'b0, irq}, 32'd1);
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 6'h3C;
    #2 rst = 1'b1;
    #1;
    chk("mid rst ctrl_in", ctrl_in, 32'h0000_1F3C);
    chk("mid rst x_in", x_in, 32'h0);
    chk("mid rst irq", {31'b0, irq}, 32'h0);
    chk("mid rst pready", {31'b0, pready}, 32'h0);
    chk("mid rst pslverr", {31'b0, pslverr}, 32'h0);
    chk("mid rst prdata", prdata, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk); rst = 1'b0;
    rd_chk("job after rst", 6'h24, 32'd0);
    rd_chk("en after rst", 6'h1C, 32'd0);
    rd_chk("stat after rst", 6'h20, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
